seq_restoring_divider: RTL
==========================

// Module: seq_restoring_divider
// PURPOSE
//  Multi-cycle unsigned restoring divider; the inverse of the 2x3 array multiplier.
//  Recovers quotient/remainder from a product-width dividend and a multiplier-width divisor.
//  Sits beside the multiplier in the arithmetic datapath with a start/done handshake.
//  Produces one quotient bit per clock.
// PARAMETERS
//  DW  5  dividend/quotient width (matches multiplier product width)
//  VW  3  divisor/remainder width (matches widest multiplier operand)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  start      in   1   request; sampled only when ready=1
//  dividend   in   DW  unsigned dividend, captured with start
//  divisor    in   VW  unsigned divisor, captured with start
//  ready      out  1   1 = idle, start will be accepted
//  done       out  1   one-cycle pulse, results valid
//  quotient   out  DW  floor(dividend/divisor)
//  remainder  out  VW  dividend mod divisor
//  div_by_zero out 1   set with done when captured divisor==0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, ready=1, done=0, quotient=0, remainder=0, div_by_zero=0.
//  States: IDLE -> CALC -> DONE -> IDLE.
//  IDLE: ready=1. start=1 at edge -> latch operands, count=DW-1, partial rem R=0 (VW+1 bits);
//    divisor!=0 -> CALC; divisor==0 -> DONE directly.
//  CALC (DW cycles, count DW-1..0): R'={R[VW-1:0],dividend[count]}; if R'>=divisor: R=R'-divisor,
//    q[count]=1 else R=R', q[count]=0. Leave at count==0 -> DONE. ready=0.
//  DONE (1 cycle): done=1, ready=0; quotient/remainder/div_by_zero updated on entry.
//  Latency: start edge to done high = DW+1 cycles (1 cycle for divide-by-zero).
//  Outputs hold last result until next DONE; cleared only by reset.
//  Divide by zero: quotient={DW{1'b1}}, remainder=0, div_by_zero=1. div_by_zero=0 for all other results.
//  start while ready=0: ignored, no queuing; operand inputs are don't-care outside the start edge.
//  start held high continuously: a new op is accepted on the cycle after DONE (back-to-back, no gap beyond IDLE).
//  Internal R needs VW+1 bits: the shifted value can reach 2*divisor-1.
//  Remainder result always < divisor; quotient*divisor+remainder==dividend (non-zero divisor).
//  Reset mid-CALC: abort immediately, no done pulse, outputs return to reset values.
// STRUCTURE
//  Package divider_pkg: state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2), default DW/VW.
//  Sub-module divider_step: combinational shift-compare-subtract stage
//    (in: R, next dividend bit, divisor; out: R_next, q_bit).
//  Top holds FSM, bit counter ($clog2(DW) bits), operand/quotient registers.
// TESTING
//  1 Reset: rst_n=0 -> ready=1, done=0, quotient=0, remainder=0, div_by_zero=0.
//  2 Exhaustive: dividend 0..31 x divisor 1..7 -> quotient==a/b, remainder==a%b;
//    done exactly 6 cycles after start; also check against multiplier: q*b+r==a.
//  3 Divisor 0, dividend 13 -> done after 1 cycle, quotient=5'b11111, remainder=0, div_by_zero=1.
//  4 start=1 during CALC with new operands (e.g. 9/2 running, 31/7 offered) -> ignored;
//    result 4 r1; one done pulse only.
//  5 rst_n pulsed low mid-CALC of 30/7 -> outputs cleared at once, no done;
//    next 30/7 -> 4 r2.
//  6 start held high with 31/1 then 0/3 -> back-to-back results 31 r0 then 0 r0, ready low only while busy.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_e : controller states (IDLE -> CALC -> DONE -> IDLE)
//   DW_DEF  : default dividend/quotient width (multiplier product width)
//   VW_DEF  : default divisor/remainder width (widest multiplier operand)
package divider_pkg;
  localparam int DW_DEF = 5;
  localparam int VW_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/divider_step.sv
// One restoring-division step, purely combinational.
//   r_i      : partial remainder so far (always < divisor, so the top bit is 0)
//   bit_i    : next dividend bit, MSB first
//   divisor_i: divisor
//   r_o      : partial remainder after this step
//   q_o      : quotient bit produced by this step
module divider_step
  import divider_pkg::*;
#(
  parameter int VW = VW_DEF
) (
  input  logic [VW:0]   r_i,
  input  logic          bit_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW:0]   r_o,
  output logic          q_o
);
  // Shifted value can reach 2*divisor-1, hence the extra bit.
  logic [VW:0] r_sh;

  assign r_sh = {r_i[VW-1:0], bit_i};
  assign q_o  = (r_sh >= {1'b0, divisor_i});
  assign r_o  = q_o ? (r_sh - {1'b0, divisor_i}) : r_sh;
endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request, taken only while ready=1
//   dividend    : DW-bit dividend, captured with start
//   divisor     : VW-bit divisor, captured with start
//   ready       : idle, start will be accepted
//   done        : one-cycle pulse, result registers just updated
//   quotient    : floor(dividend/divisor), all ones on divide by zero
//   remainder   : dividend mod divisor, 0 on divide by zero
//   div_by_zero : captured divisor was zero
// Results hold until the next completion; only reset clears them.
module seq_restoring_divider
  import divider_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          ready,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW:0]   rem_q, rem_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [DW-1:0] quotient_q, quotient_d;
  logic [VW-1:0] remainder_q, remainder_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   step_r;
  logic          step_q;

  divider_step #(.VW(VW)) u_step (
    .r_i      (rem_q),
    .bit_i    (dvd_q[cnt_q]),
    .divisor_i(dvs_q),
    .r_o      (step_r),
    .q_o      (step_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d = dividend;
          dvs_d = divisor;
          cnt_d = CW'(DW - 1);
          rem_d = '0;
          quo_d = '0;
          if (divisor == '0) begin
            // No iterations needed: report straight away.
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = '0;
            dbz_d       = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d        = step_r;
        quo_d[cnt_q] = step_q;
        cnt_d        = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d     = DONE;
          quotient_d  = quo_d;
          // Final remainder is < divisor, so the top bit is always 0.
          remainder_d = step_r[VW-1:0];
          dbz_d       = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign ready       = (state_q == IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
endmodule
